muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the pipelined CPU. Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU as a 32-step shift-add or restoring-divide loop.
- The single-cycle ALU stays purely combinational. This block sits beside it in EX.
- Its busy output feeds the hazard unit, which stalls MFHI/MFLO and any new mul/div while the loop runs.

Parameters:
- WIDTH, 32, operand width. Iteration count = WIDTH. Only 32 is verified.

Ports:
- clk  in  1  pipeline clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  issue strobe from EX, qualified by md_op
- md_op  in  3  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO (others = no-op)
- A  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- B  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  pipeline flush of the issuing instruction
- busy  out  1  loop in progress
- done  out  1  one-cycle pulse when HI/LO take a mul/div result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset mid-loop discards the operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - start with MTHI/MTLO: hi or lo <= A at the next edge. No busy, no done. Stays IDLE.
  - start with a mul/div op: latch operand magnitudes, sign flags and op. Counter <= 0. Go to RUN.
  - Signed ops take |A|, |B|. Unsigned ops take the raw values.
  - start with an invalid md_op: ignored.
- RUN: one shift-add (mul) or restore-subtract (div) step per cycle, counter++. After step WIDTH-1, go to FIX.
- FIX (one cycle):
  - Apply sign correction and write hi/lo. done=1 for this cycle. Next state IDLE.
  - MULT: negate the 64-bit product if the sign flags differ.
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
- busy=1 in RUN and FIX. busy rises the cycle after start is accepted.
- Latency: start accepted at edge 0, hi/lo valid and done=1 after edge 33. A new start is accepted in the same cycle done is high, because the state is IDLE next cycle.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (B==0, DIV or DIVU): no loop. IDLE -> FIX directly, then hi=A, lo=32'hFFFFFFFF, done=1. Total latency 2 edges.
- DIV 0x80000000 / -1: lo=0x80000000, hi=0. Wraps, no trap.
- start while busy: ignored entirely, including MTHI/MTLO. The hazard unit must hold the instruction until busy=0.
- flush:
  - In RUN or FIX: abort to IDLE next edge. hi/lo unchanged, no done.
  - Coincident with start in IDLE: start is ignored.
- hi/lo change only at FIX completion or on MTHI/MTLO.
- All arithmetic is unsigned internally on WIDTH+1 / 2*WIDTH-bit registers. Negation is two's complement modulo the width.

Decomposition:
- Shared package (ctrl_encode_def.v): MD_* op codes (3-bit) and the state encoding (MDS_IDLE/RUN/FIX).
- One natural sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract) on the partial product or remainder. The sequencer owns state, counter, sign fix and HI/LO.

Test Plan:
- MULT A=-3 (0xFFFFFFFD), B=5 -> busy 1 after the next edge; done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU A=7, B=2 -> lo=3, hi=1.
- DIVU A=0x1234, B=0 -> done after 2 edges; hi=0x1234, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF started; at cycle 10 pulse start with MTHI A=5 (ignored), then flush at cycle 12 -> no done; hi/lo keep prior values; busy=0 after cycle 13.
- MTLO A=0xCAFE from IDLE -> lo=0xCAFE next edge, busy stays 0. Back-to-back MULT issued in the done cycle -> accepted; second result at +33.
- Deassert rstn asynchronously mid-RUN (between edges) -> busy, done, hi and lo go to 0 immediately. After release, a new MULT 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - op codes and sequencer state encoding for muldiv_seq
`timescale 1ns/1ps
package muldiv_seq_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add or restoring-divide iteration
`timescale 1ns/1ps
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply: acc = {partial, multiplier}, shifted right each step.
    // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        acc_nxt = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH])
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
`timescale 1ns/1ps
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t            state;
    logic [CW-1:0]        cnt;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     opnd;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    always_comb begin
        signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
        a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
        b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
    end

    // Sign correction applied on the way into HI/LO.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        if (is_div) begin
            fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            fix_lo = prod_fix[WIDTH-1:0];
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= MDS_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MDS_IDLE: begin
                    if (start && !flush) begin
                        case (md_op)
                            MD_MTHI: hi <= A;
                            MD_MTLO: lo <= A;
                            MD_MULT, MD_MULTU: begin
                                acc    <= {{WIDTH{1'b0}}, b_mag};
                                opnd   <= a_mag;
                                is_div <= 1'b0;
                                neg_q  <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                                neg_r  <= 1'b0;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= MDS_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                is_div <= 1'b1;
                                busy   <= 1'b1;
                                cnt    <= '0;
                                if (B == '0) begin
                                    // Divide by zero skips the loop: HI=A, LO=all ones.
                                    acc   <= {A, {WIDTH{1'b1}}};
                                    neg_q <= 1'b0;
                                    neg_r <= 1'b0;
                                    state <= MDS_FIX;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, a_mag};
                                    opnd  <= b_mag;
                                    neg_q <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                                    neg_r <= signed_op && A[WIDTH-1];
                                    state <= MDS_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MDS_RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= MDS_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1))
                            state <= MDS_FIX;
                    end
                end
                MDS_FIX: begin
                    busy  <= 1'b0;
                    state <= MDS_IDLE;
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MDS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq
`timescale 1ns/1ps
module tb_muldiv_seq;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .md_op (md_op),
        .A     (a),
        .B     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} straight from the arithmetic definition.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] ux;
        logic [63:0] uy;
        int          q;
        int          r;
        sx = x;
        sy = y;
        ux = {32'd0, x};
        uy = {32'd0, y};
        ref_md = '0;
        case (op)
            OP_MULT: begin
                sp = longint'(sx) * longint'(sy);
                ref_md = sp;
            end
            OP_MULTU: ref_md = ux * uy;
            OP_DIV: begin
                if (y == 32'd0)
                    ref_md = {x, 32'hFFFFFFFF};
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                    ref_md = {32'd0, 32'h80000000};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    ref_md = {r, q};
                end
            end
            OP_DIVU: begin
                if (y == 32'd0)
                    ref_md = {x, 32'hFFFFFFFF};
                else
                    ref_md = {x % y, x / y};
            end
            default: ref_md = {mhi, mlo};
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
    endtask

    // Called right after issue() at a negedge; returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0)
            check({tag, "_timeout"}, 64'd0, 64'd1);
        else begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] exp;
        int          lat;
        exp = ref_md(op, x, y);
        lat = ((op == OP_DIV || op == OP_DIVU) && y == 32'd0) ? 1 : 33;
        issue(op, x, y);
        wait_done(tag, lat);
        check({tag, "_hilo"}, {hi, lo}, exp);
        mhi = exp[63:32];
        mlo = exp[31:0];
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic        seen;

        #12;
        check("reset_outputs", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_md("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        run_md("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2);
        run_md("divu_7_2", OP_DIVU, 32'd7, 32'd2);
        run_md("divu_by0", OP_DIVU, 32'h1234, 32'd0);
        run_md("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_md("div_by0", OP_DIV, 32'hFFFFFF00, 32'd0);

        // MTLO from idle
        @(negedge clk);
        issue(OP_MTLO, 32'hCAFE, 32'd0);
        @(negedge clk);
        start = 1'b0;
        mlo = 32'hCAFE;
        check("mtlo_lo", {32'd0, lo}, {32'd0, mlo});
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        issue(OP_MTHI, 32'h0BAD_F00D, 32'd0);
        @(negedge clk);
        start = 1'b0;
        mhi = 32'h0BAD_F00D;
        check("mthi_hi", {32'd0, hi}, {32'd0, mhi});

        // Back-to-back: second MULT issued during the done cycle
        run_md("b2b_first", OP_MULT, 32'd12345, 32'hFFFFFF85);
        run_md("b2b_second", OP_MULTU, 32'hDEADBEEF, 32'h01234567);

        // Flush mid-loop, with an ignored MTHI while busy
        @(negedge clk);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        seen = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 9) issue(OP_MTHI, 32'd5, 32'd0);
            if (k == 10) start = 1'b0;
            if (k == 11) flush = 1'b1;
            if (k == 12) begin
                flush = 1'b0;
                check("flush_busy_drop", {63'd0, busy}, 64'd0);
            end
            if (done) seen = 1'b1;
        end
        check("flush_no_done", {63'd0, seen}, 64'd0);
        check("flush_hilo_kept", {hi, lo}, {mhi, mlo});

        // Flush coincident with start in idle is ignored
        issue(OP_MTLO, 32'h5555AAAA, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_ignored", {31'd0, busy, lo}, {32'd0, mlo});

        // Randomized mix, issued back-to-back where possible
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            if ($urandom_range(0, 15) == 0) begin
                x = 32'h80000000;
                y = 32'hFFFFFFFF;
            end
            if (op <= OP_DIVU) begin
                run_md($sformatf("rnd%0d_op%0d", i, op), op, x, y);
            end else begin
                issue(op, x, y);
                @(negedge clk);
                start = 1'b0;
                if (op == OP_MTHI) mhi = x;
                if (op == OP_MTLO) mlo = x;
                check($sformatf("rnd%0d_op%0d_hilo", i, op), {hi, lo}, {mhi, mlo});
                check($sformatf("rnd%0d_op%0d_busy", i, op), {63'd0, busy}, 64'd0);
            end
        end

        // Asynchronous reset between edges in the middle of a loop
        @(negedge clk);
        issue(OP_MULT, 32'd99, 32'd77);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset", {30'd0, busy, done, hi, lo}, 64'd0);
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {63'd0, busy}, 64'd0);
        run_md("mult_6x7", OP_MULT, 32'd6, 32'd7);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
